lane_serializer: RTL
====================

# lane_serializer

- Parametrised parallel-to-serial converter.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it over LANES serial lines, LSB-first or MSB-first.
- Drives a one-cycle `start` sync pulse ahead of the first beat for the downstream deserializer.
- Sits between a word-producing core and the chip's serial output pads. Unlike the free-running generation, it is idle until a word is offered.

## Interface
- WIDTH, 8, parallel word width; must be a multiple of LANES, otherwise elaboration error.
- LANES, 1, number of serial output lines; BEATS = WIDTH/LANES.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  parallel word; captured on acceptance.
- valid_in  input  1  producer offers data_in.
- msb_first  input  1  bit order; captured on acceptance.
- ready_out  output  1  block can accept a word this cycle.
- serial_out  output  LANES  serial data, one bit per lane per beat.
- start  output  1  sync pulse, one cycle before beat 0.
- busy  output  1  high from acceptance until the last beat (parity beat included) has been driven.

## Operation
- All outputs are registered, except ready_out, which is decoded from state.
- States:
  - IDLE: ready_out=1. On valid_in&&ready_out, capture data_in→shadow and msb_first→order, set start=1, go to START.
  - START: start=0, beat=0, drive beat 0, go to SEND.
  - SEND: at beat==BEATS-1, go to PARITY if parity is enabled, else IDLE; otherwise beat+1 and drive the next beat.
  - PARITY: drive the parity bits, go to IDLE.
- Lane mapping, beat b, lane l:
  - LSB-first: bit b·LANES+l.
  - MSB-first: bit WIDTH−LANES·(b+1)+l.
- serial_out=0 in every cycle in which no beat is being driven.
- Beat counter width is max(1,$clog2(BEATS)). BEATS=1 is legal: SEND lasts one cycle.
- data_in, msb_first and valid_in are ignored while busy. A deasserted valid_in never aborts a transfer.
- With valid_in low, the block stays in IDLE, start never pulses and serial_out stays 0.
- Reset asserted mid-transfer aborts immediately; the partial word is never resumed.

## Timing
- Reset values: ready_out=1, serial_out=0, start=0, busy=0; state=IDLE, beat=0, shadow=0.
- Acceptance edge k gives:
  - start=1 during cycle k+1.
  - Beat b on serial_out during cycle k+2+b.
  - Parity, if enabled, during cycle k+2+BEATS.
- ready_out returns high in the cycle after the final beat:
  - Word period = BEATS+2 cycles without parity.
  - Word period = BEATS+3 cycles with parity.
- busy=1 from cycle k+1 through the final beat cycle.

## Configuration
- SERIALIZER_PARITY_EN defined: adds the PARITY state and one extra beat per word. Each lane carries the even parity (XOR) of the BEATS bits it sent in that word.
- SERIALIZER_PARITY_EN undefined: no PARITY state, no parity logic; SEND goes directly to IDLE.

## Structure
- Package lane_serializer_pkg holds typedef state_t {IDLE, START, SEND, PARITY} and the BEATS/counter-width helper function.
- No sub-module needed: one always_ff for state, counter, shadow and outputs, plus one combinational lane-select block.

## Test plan
- WIDTH=8, LANES=1, data 0xC1, LSB-first, valid at edge k -> start=1 at k+1; serial_out 1,0,0,0,0,0,1,1 over k+2..k+9; ready_out=1 at k+10.
- Same word, msb_first=1 -> serial_out 1,1,0,0,0,0,0,1.
- WIDTH=8, LANES=2, data 0xB4, LSB-first -> serial_out 2'b00, 2'b01, 2'b11, 2'b10; with SERIALIZER_PARITY_EN, parity beat 2'b00.
- LANES=1, 0xC1, SERIALIZER_PARITY_EN -> parity beat 1; ready_out high at k+11; back-to-back valid accepted exactly every 11 cycles.
- valid_in low for 50 cycles -> ready_out=1, start=0, serial_out=0 throughout; data_in toggled during SEND -> transmitted word unchanged.
- rst pulsed at beat 3 -> all outputs immediately at reset values; next accepted word 0x5A is transmitted intact.

Source files
------------

// File: rtl/lane_serializer_pkg.sv
// lane_serializer_pkg: shared types and sizing helpers for lane_serializer.
// Holds the FSM state encoding and the counter-width helper.
package lane_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        PARITY
    } state_t;

    // max(1, $clog2(n)): keeps a counter or index at least one bit wide
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// lane_serializer: WIDTH-bit word in via valid/ready, out over LANES serial
// lines (LSB- or MSB-first), preceded by a one-cycle start pulse.
// Ports: clk, rst (async, active-high), data_in/valid_in/msb_first (in),
//        ready_out, serial_out[LANES], start, busy (out).
// Build option: define SERIALIZER_PARITY_EN to append one even-parity beat
// per word (each lane carries the XOR of the bits it sent).
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             msb_first,
    output logic             ready_out,
    output logic [LANES-1:0] serial_out,
    output logic             start,
    output logic             busy
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = cnt_width(BEATS);
    localparam int IW    = cnt_width(WIDTH);

    typedef logic [CW-1:0] beat_t;
    localparam beat_t LAST = beat_t'(BEATS - 1);

    if ((WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("lane_serializer: WIDTH must be a multiple of LANES");
    end

    state_t           r_state;
    beat_t            r_beat;
    logic [WIDTH-1:0] r_shadow;
    logic             r_order;
    logic [LANES-1:0] r_serial;
    logic             r_start;
    logic             r_busy;

    beat_t            w_sel;
    int               w_off;
    logic [LANES-1:0] w_bits;

    // Bits for the beat about to be driven: beat 0 when leaving START,
    // beat+1 while in SEND.
    always_comb begin
        w_sel  = (r_state == SEND) ? r_beat + beat_t'(1) : '0;
        w_off  = r_order ? (WIDTH - LANES * (int'(w_sel) + 1))
                         : (LANES * int'(w_sel));
        w_bits = '0;
        for (int l = 0; l < LANES; l++) begin
            w_bits[l] = r_shadow[IW'(w_off + l)];
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic [LANES-1:0] w_par;

    // Per-lane XOR is the same whichever order the beats went out in
    always_comb begin
        w_par = '0;
        for (int b = 0; b < BEATS; b++) begin
            w_par = w_par ^ r_shadow[b*LANES +: LANES];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_shadow <= '0;
            r_order  <= 1'b0;
            r_serial <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_shadow <= data_in;
                        r_order  <= msb_first;
                        r_start  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_start  <= 1'b0;
                    r_beat   <= '0;
                    r_serial <= w_bits;
                    r_state  <= SEND;
                end
                SEND: begin
                    if (r_beat == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                        r_serial <= w_par;
                        r_state  <= PARITY;
`else
                        r_serial <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
`endif
                    end else begin
                        r_beat   <= r_beat + beat_t'(1);
                        r_serial <= w_bits;
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    r_serial <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
`endif
                default: begin
                    r_serial <= '0;
                    r_start  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ready_out  = (r_state == IDLE);
    assign serial_out = r_serial;
    assign start      = r_start;
    assign busy       = r_busy;

endmodule
